// File: rtl/game_judge_if.sv
// Signal bundle between the debounced buttons / start control and the round judge.
// No valid/ready handshake: start and buttons are levels sampled every rising clock
// edge; right/wrong are one-cycle pulses; every other judge output is a held level.
interface game_judge_if;
  logic       start;
  logic       button_left;
  logic       button_right;
  logic [1:0] target;
  logic       right;
  logic       wrong;
  logic [3:0] score;
  logic [3:0] score10;
  logic [1:0] lives_left;
  logic [2:0] state;
  logic       game_over;

  modport slave (
    input  start, button_left, button_right,
    output target, right, wrong, score, score10, lives_left, state, game_over
  );

  modport master (
    output start, button_left, button_right,
    input  target, right, wrong, score, score10, lives_left, state, game_over
  );
endinterface

// File: rtl/game_judge.sv
// Round controller for the two-button reaction game: random target, timed response
// window, first-press judging, BCD score and lives, game over at zero lives.
module game_judge #(
  parameter int unsigned WINDOW = 50_000_000,
  parameter int unsigned GAP    = 12_500_000,
  parameter int unsigned LIVES  = 3,
  parameter logic [7:0]  SEED   = 8'hA5
) (
  input logic         clock,
  input logic         reset,
  game_judge_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WINDOW = 3'd2,
    S_GAP    = 3'd3,
    S_OVER   = 3'd4
  } state_e;

  localparam logic [31:0] WIN_LOAD   = 32'(WINDOW - 1);
  localparam logic [31:0] GAP_LOAD   = 32'(GAP - 1);
  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        btn_l_q, btn_r_q;
  logic [1:0]  target_q, target_d;
  logic        right_q, right_d;
  logic        wrong_q, wrong_d;
  logic [3:0]  score_q, score_d;
  logic [3:0]  score10_q, score10_d;
  logic [1:0]  lives_q, lives_d;

  logic       ev_l, ev_r, ev_tgt, ev_oth;
  logic       hit, miss;
  logic [1:0] new_target;

  // Previous samples reset high so a button held through reset is not a press.
  assign ev_l       = bus.button_left  & ~btn_l_q;
  assign ev_r       = bus.button_right & ~btn_r_q;
  assign ev_tgt     = (target_q == 2'b10) ? ev_l : ev_r;
  assign ev_oth     = (target_q == 2'b10) ? ev_r : ev_l;
  assign new_target = lfsr_q[0] ? 2'b10 : 2'b01;
  assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    target_d  = target_q;
    score_d   = score_q;
    score10_d = score10_q;
    lives_d   = lives_q;
    right_d   = 1'b0;
    wrong_d   = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        target_d = 2'b00;
        if (bus.start) begin
          state_d   = S_WINDOW;
          timer_d   = WIN_LOAD;
          target_d  = new_target;
          score_d   = 4'd0;
          score10_d = 4'd0;
          lives_d   = LIVES_INIT;
        end
      end
      S_WINDOW: begin
        timer_d = timer_q - 32'd1;
        // A press in the final cycle is judged; the timeout only counts when nothing was pressed.
        if (ev_l || ev_r) begin
          hit  = ev_tgt & ~ev_oth;
          miss = ~(ev_tgt & ~ev_oth);
        end else if (timer_q == 32'd0) begin
          miss = 1'b1;
        end
        if (hit || miss) begin
          state_d  = S_GAP;
          timer_d  = GAP_LOAD;
          target_d = 2'b00;
        end
      end
      S_GAP: begin
        target_d = 2'b00;
        if (timer_q == 32'd0) begin
          if (lives_q == 2'd0) begin
            state_d = S_OVER;
          end else begin
            state_d  = S_WINDOW;
            timer_d  = WIN_LOAD;
            target_d = new_target;
          end
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        target_d = 2'b00;
      end
    endcase

    if (hit) begin
      right_d = 1'b1;
      if (!(score10_q == 4'd9 && score_q == 4'd9)) begin
        if (score_q == 4'd9) begin
          score_d   = 4'd0;
          score10_d = score10_q + 4'd1;
        end else begin
          score_d = score_q + 4'd1;
        end
      end
    end

    if (miss) begin
      wrong_d = 1'b1;
      if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= 32'd0;
      lfsr_q    <= SEED;
      btn_l_q   <= 1'b1;
      btn_r_q   <= 1'b1;
      target_q  <= 2'b00;
      right_q   <= 1'b0;
      wrong_q   <= 1'b0;
      score_q   <= 4'd0;
      score10_q <= 4'd0;
      lives_q   <= LIVES_INIT;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      lfsr_q    <= lfsr_d;
      btn_l_q   <= bus.button_left;
      btn_r_q   <= bus.button_right;
      target_q  <= target_d;
      right_q   <= right_d;
      wrong_q   <= wrong_d;
      score_q   <= score_d;
      score10_q <= score10_d;
      lives_q   <= lives_d;
    end
  end

  assign bus.target     = target_q;
  assign bus.right      = right_q;
  assign bus.wrong      = wrong_q;
  assign bus.score      = score_q;
  assign bus.score10    = score10_q;
  assign bus.lives_left = lives_q;
  assign bus.state      = state_q;
  assign bus.game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_game_judge.sv
// Directed bench for game_judge with WINDOW=8, GAP=4, LIVES=3; scoring pulses are
// checked against an expected queue, everything else against a small reference model.
module tb_game_judge;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk;
  logic reset;
  game_judge_if gif ();

  game_judge #(.WINDOW(8), .GAP(4), .LIVES(3), .SEED(SEED)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (gif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference state ----------------
  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q[$];
  int   m_score = 0;
  int   m_lives = 3;
  logic [7:0] lfsr_m, lfsr_prev;

  always @(posedge clk) begin
    lfsr_prev <= lfsr_m;
    if (reset) lfsr_m <= SEED;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  function automatic logic [7:0] bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    logic [13:0] e;
    #1;
    if (!reset && (gif.right || gif.wrong)) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {30'd0, gif.right, gif.wrong}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse", {18'd0, gif.right, gif.wrong, gif.score10, gif.score, gif.lives_left}, {18'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hit();
    if (m_score < 99) m_score++;
    exp_q.push_back({2'b10, bcd(m_score), 2'(m_lives)});
  endtask

  task automatic push_miss();
    if (m_lives > 0) m_lives--;
    exp_q.push_back({2'b01, bcd(m_score), 2'(m_lives)});
  endtask

  task automatic check_target(input string name);
    check(name, {30'd0, gif.target}, {30'd0, (lfsr_prev[0] ? 2'b10 : 2'b01)});
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (gif.state !== s && n < budget) begin
      step();
      n++;
    end
    check(name, {29'd0, gif.state}, {29'd0, s});
  endtask

  task automatic press_target();
    logic left;
    left = (gif.target == 2'b10);
    gif.button_left  = left;
    gif.button_right = !left;
    push_hit();
    step();
    gif.button_left  = 1'b0;
    gif.button_right = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  {29'd0, gif.state},      32'd0);
    check({tag, "_target"}, {30'd0, gif.target},     32'd0);
    check({tag, "_pulses"}, {30'd0, gif.right, gif.wrong}, 32'd0);
    check({tag, "_score"},  {24'd0, gif.score10, gif.score}, 32'd0);
    check({tag, "_lives"},  {30'd0, gif.lives_left}, 32'd3);
    check({tag, "_over"},   {31'd0, gif.game_over},  32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset            = 1'b1;
    gif.start        = 1'b0;
    gif.button_left  = 1'b0;
    gif.button_right = 1'b0;
    repeat (2) step();
    check_reset_values("reset");
    reset = 1'b0;
    step();
    check("idle_hold", {29'd0, gif.state}, 32'd0);

    // first hit, three cycles after start
    gif.start = 1'b1;
    step();
    gif.start = 1'b0;
    check("start_window", {29'd0, gif.state}, 32'd2);
    check_target("start_target");
    repeat (2) step();
    press_target();
    check("hit_gap", {29'd0, gif.state}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap_len", {29'd0, gif.state}, 32'd3);
    end
    step();
    check("gap_end", {29'd0, gif.state}, 32'd2);
    check_target("gap_target");

    // timeout after exactly 8 window cycles
    push_miss();
    for (int i = 0; i < 7; i++) begin
      step();
      check("window_len", {29'd0, gif.state}, 32'd2);
    end
    step();
    check("timeout_gap", {29'd0, gif.state}, 32'd3);

    // wrong-side press
    wait_state(3'd2, 8, "to_window2");
    check_target("window2_target");
    gif.button_left  = (gif.target != 2'b10);
    gif.button_right = (gif.target == 2'b10);
    push_miss();
    step();
    gif.button_left  = 1'b0;
    gif.button_right = 1'b0;
    check("wrong_side_gap", {29'd0, gif.state}, 32'd3);

    // press in GAP is ignored, start is ignored in GAP
    gif.button_left = 1'b1;
    gif.start       = 1'b1;
    step();
    gif.button_left = 1'b0;
    gif.start       = 1'b0;
    check("start_ignored_gap", {29'd0, gif.state}, 32'd3);

    // both buttons held from GAP into WINDOW: no event
    gif.button_left  = 1'b1;
    gif.button_right = 1'b1;
    wait_state(3'd2, 8, "to_window3");
    check_target("window3_target");
    repeat (3) step();
    check("held_no_event", {29'd0, gif.state}, 32'd2);
    gif.button_left  = 1'b0;
    gif.button_right = 1'b0;
    step();

    // both rise together: miss, no score change
    gif.button_left  = 1'b1;
    gif.button_right = 1'b1;
    push_miss();
    step();
    gif.button_left  = 1'b0;
    gif.button_right = 1'b0;
    check("both_gap", {29'd0, gif.state}, 32'd3);

    // out of lives
    wait_state(3'd4, 10, "to_over");
    check("over_flag", {31'd0, gif.game_over}, 32'd1);
    check("over_score", {24'd0, gif.score10, gif.score}, 32'h01);
    check("over_lives", {30'd0, gif.lives_left}, 32'd0);
    check("over_target", {30'd0, gif.target}, 32'd0);
    gif.button_left = 1'b1;
    step();
    gif.button_left = 1'b0;
    step();
    check("over_ignores_press", {29'd0, gif.state}, 32'd4);

    // restart
    gif.start = 1'b1;
    step();
    gif.start = 1'b0;
    m_score = 0;
    m_lives = 3;
    check("restart_state", {29'd0, gif.state}, 32'd2);
    check("restart_score", {24'd0, gif.score10, gif.score}, 32'h00);
    check("restart_lives", {30'd0, gif.lives_left}, 32'd3);
    check_target("restart_target");
    gif.start = 1'b1;
    step();
    gif.start = 1'b0;
    check("start_ignored_window", {29'd0, gif.state}, 32'd2);

    // 100 hits: BCD carry at 10, saturation at 99
    for (int i = 1; i <= 100; i++) begin
      if (gif.state !== 3'd2) wait_state(3'd2, 10, "hit_loop_window");
      press_target();
      if (i == 10)  check("score_10",  {24'd0, gif.score10, gif.score}, 32'h10);
      if (i == 99)  check("score_99",  {24'd0, gif.score10, gif.score}, 32'h99);
      if (i == 100) check("score_sat", {24'd0, gif.score10, gif.score}, 32'h99);
    end

    // reset mid-window with left held; the coincident press is dropped
    wait_state(3'd2, 10, "to_window_reset");
    gif.button_left = 1'b1;
    reset = 1'b1;
    step();
    check_reset_values("midreset");
    reset = 1'b0;
    m_score = 0;
    m_lives = 3;
    step();
    gif.start = 1'b1;
    step();
    gif.start = 1'b0;
    check("post_reset_window", {29'd0, gif.state}, 32'd2);
    check_target("post_reset_target");
    repeat (2) step();
    check("held_thru_reset", {29'd0, gif.state}, 32'd2);
    gif.button_left = 1'b0;
    step();
    press_target();
    check("post_reset_hit", {29'd0, gif.state}, 32'd3);

    repeat (2) step();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog timeout total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/game_judge.md
# game_judge

Round controller for the two-button reaction game. It sequences each round: it presents a pseudo-random target side, times a response window, and judges the first button press. It issues one-cycle `right`/`wrong` pulses, maintains the BCD score and lives, and ends the game when lives reach zero. It sits between the debounced button inputs and the score/LED display logic, and is the sole source of scoring events.

## Interface
- `WINDOW`, default 50_000_000: response-window length in cycles (≥2).
- `GAP`, default 12_500_000: idle cycles between rounds (≥1).
- `LIVES`, default 3: lives per game (1–3).
- `SEED`, default 8'hA5: LFSR reset value (nonzero).

- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; start/restart request.
- `button_left`  in  1  debounced level, high = pressed.
- `button_right`  in  1  debounced level, high = pressed.
- `target`  out  2  2'b10 = left, 2'b01 = right, 2'b00 = none.
- `right`  out  1  one-cycle hit pulse.
- `wrong`  out  1  one-cycle miss pulse.
- `score`  out  4  BCD ones digit.
- `score10`  out  4  BCD tens digit.
- `lives_left`  out  2  remaining lives.
- `state`  out  3  current FSM state code.
- `game_over`  out  1  high while in OVER.

## Operation
**Button edges**
- Press event = input high this cycle and low in the previous registered sample.
- The previous-sample registers reset to 1, so a button held through reset does not generate an event.

**LFSR**
- 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
- Reset to `SEED`; advances every cycle in every state.
- Target is latched on each entry to WINDOW: `lfsr[0]`=1 selects left, 0 selects right.

**FSM states**
- IDLE=0: `target`=00. A `start` high moves to WINDOW; on that transition score←00, lives←`LIVES`, timer←`WINDOW`−1.
- WINDOW=2: `target` holds the latched side; the timer decrements each cycle.
  - Event on the target side only → hit.
  - Event on the other side only, or on both sides in the same cycle → miss.
  - Timer==0 with no event → miss.
  - Press and timeout in the same cycle: the press is judged and timeout is ignored.
  - Either outcome moves to GAP with timer←`GAP`−1.
- GAP=3: `target`=00; presses are ignored. At timer==0: lives==0 → OVER, else → WINDOW with a new target and timer←`WINDOW`−1.
- OVER=4: `game_over`=1, `target`=00; score and lives hold. A `start` high behaves as from IDLE.
- `start` is ignored in WINDOW and GAP.
- Any state with `reset`=1 → IDLE.

**Arithmetic**
- Hit: `right` pulses; score increments in BCD. Ones digit 9 → 0 with tens +1. At 99 the score saturates, and `right` still pulses.
- Miss: `wrong` pulses; lives decrement, floor 0.
- `right` and `wrong` are never high in the same cycle.

**Reset values**
- `target`=00, `right`=0, `wrong`=0, `score`=0, `score10`=0, `lives_left`=`LIVES`, `state`=0, `game_over`=0.

## Timing
- All outputs are registered.
- Button sampled high at edge k (low at k−1) → `right`/`wrong`, updated score/lives, and `state`=GAP are all visible after edge k. Latency is one cycle from the input.
- WINDOW lasts exactly `WINDOW` cycles when no press occurs; the timeout `wrong` pulse coincides with the first GAP cycle.
- GAP lasts exactly `GAP` cycles.
- `start` sampled high in IDLE/OVER at edge k → `state`=WINDOW and `target`≠00 after edge k.
- Reset asserted at edge k → all reset values after edge k, regardless of state. Pulses in flight are dropped.

## Test plan
All scenarios use `WINDOW`=8, `GAP`=4, `LIVES`=3.
- Reset, assert `start`, press the target side 3 cycles later → `right` high exactly 1 cycle, score 00→01, GAP for 4 cycles, then WINDOW with `target`≠00.
- No press → after 8 WINDOW cycles, `wrong` pulses once and `lives_left` goes 3→2. Wrong-side press → `wrong`, lives 2→1.
- Both buttons rise in the same cycle → `wrong`, no score change. A press in GAP or a held button → no event.
- 10 consecutive hits → `score`=0, `score10`=1. 100 hits → 99 held, `right` pulses on the 100th.
- Three misses → `state`=4, `game_over`=1, score held, presses ignored. `start` → score 00, lives 3, `state`=2.
- `reset` mid-WINDOW with `button_left` held through release → reset values next cycle, and no event until the button is released and pressed again.
